// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller for the 5-stage RISC-V pipeline.
// Sequences multi-cycle EX ops and counts front-end stall cycles.
module pipeline_ctrl #(
    parameter int unsigned MC_LATENCY  = 8,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             ex_rs1,
    input  logic [4:0]             ex_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_mem_read,
    input  logic                   ex_branch_taken,
    input  logic                   ex_mc_start,
    input  logic [4:0]             mem_rd,
    input  logic [4:0]             wb_rd,
    input  logic                   mem_reg_write,
    input  logic                   wb_reg_write,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic                   mc_busy,
    output logic                   mc_done,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MC_WAIT = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [STALL_CNT_W-1:0] r_stall;

    logic w_mc_busy;
    logic w_mc_done;
    logic w_load_use;

    // Nearest producer wins; x0 is hardwired zero and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Multi-cycle sequencer next-state; ex_mc_start only matters in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (ex_mc_start) begin
                    w_state_nxt = ST_MC_WAIT;
                    w_cnt_nxt   = CNT_W'(MC_LATENCY - 1);
                end
            end
            ST_MC_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_mc_busy  = !reset && (((r_state == ST_RUN) && ex_mc_start) ||
                                ((r_state == ST_MC_WAIT) && (r_cnt != '0)));
        w_mc_done  = !reset && (r_state == ST_MC_WAIT) && (r_cnt == '0);
        w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    // Pipeline-register control, priority reset > mc_busy > branch > load-use.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_mc_busy) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        mc_busy = w_mc_busy;
        mc_done = w_mc_done;
        fwd_a   = reset ? FWD_RF : fwd_sel(ex_rs1);
        fwd_b   = reset ? FWD_RF : fwd_sel(ex_rs2);
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= '0;
        end else if (!pc_en && (r_stall != '1)) begin
            r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: stimulus pushes expected outputs,
// a negedge monitor pops and compares.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_mem_read, ex_branch_taken, ex_mc_start;
    logic        mem_reg_write, wb_reg_write;
    logic        pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mc_busy, mc_done;
    logic [31:0] stall_cycles;

    typedef struct packed {
        logic [5:0]  ctl;    // pc_en ifid_en idex_en ifid_flush idex_flush exmem_flush
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic        busy;
        logic        done;
        logic [31:0] stall;
    } exp_t;

    localparam logic [5:0] C_RUN = 6'b111_000;
    localparam logic [5:0] C_RST = 6'b000_111;
    localparam logic [5:0] C_LU  = 6'b001_010;
    localparam logic [5:0] C_BR  = 6'b111_110;
    localparam logic [5:0] C_MC  = 6'b000_001;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_applied = 0;
    int    n_miscmp  = 0;

    pipeline_ctrl #(.MC_LATENCY(8), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .ex_mc_start(ex_mc_start),
        .mem_rd(mem_rd), .wb_rd(wb_rd),
        .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy), .mc_done(mc_done),
        .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [5:0] ctl, input logic [1:0] fa,
                                input logic [1:0] fb, input logic busy,
                                input logic done, input int stall);
        exp_t e;
        e.ctl   = ctl;
        e.fwd_a = fa;
        e.fwd_b = fb;
        e.busy  = busy;
        e.done  = done;
        e.stall = 32'(stall);
        return e;
    endfunction

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_mc_start = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    endtask

    // Inputs are already set; queue the expectation and advance one cycle.
    task automatic step(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush,
                  fwd_a, fwd_b, mc_busy, mc_done, stall_cycles};
            n_applied++;
            if (g !== e) begin
                n_miscmp++;
                $display("FAIL %s: got ctl=%b fwd=%b/%b busy=%b done=%b stall=%0d, required ctl=%b fwd=%b/%b busy=%b done=%b stall=%0d",
                         nm, g.ctl, g.fwd_a, g.fwd_b, g.busy, g.done, g.stall,
                         e.ctl, e.fwd_a, e.fwd_b, e.busy, e.done, e.stall);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        // Reset held two checked cycles
        step("reset0", mk(C_RST, 2'b00, 2'b00, 0, 0, 0));
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
        step("reset1_fwd_masked", mk(C_RST, 2'b00, 2'b00, 0, 0, 0));
        reset = 1'b0;
        idle_inputs();
        step("idle_after_reset", mk(C_RUN, 2'b00, 2'b00, 0, 0, 0));

        // Load-use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        step("load_use_rs2", mk(C_LU, 2'b00, 2'b00, 0, 0, 0));
        idle_inputs();
        step("after_load_use", mk(C_RUN, 2'b00, 2'b00, 0, 0, 1));
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        step("load_use_x0", mk(C_RUN, 2'b00, 2'b00, 0, 0, 1));
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        step("load_use_rs1", mk(C_LU, 2'b00, 2'b00, 0, 0, 1));
        idle_inputs();
        step("idle2", mk(C_RUN, 2'b00, 2'b00, 0, 0, 2));

        // Branch overrides load-use
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; ex_branch_taken = 1'b1;
        step("branch_over_lu", mk(C_BR, 2'b00, 2'b00, 0, 0, 2));
        idle_inputs();
        step("after_branch", mk(C_RUN, 2'b00, 2'b00, 0, 0, 2));

        // Forwarding
        mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        ex_rs1 = 5'd7;
        step("fwd_mem", mk(C_RUN, 2'b10, 2'b00, 0, 0, 2));
        mem_reg_write = 1'b0;
        step("fwd_wb", mk(C_RUN, 2'b01, 2'b00, 0, 0, 2));
        mem_rd = 5'd0; wb_rd = 5'd0; ex_rs1 = 5'd0; mem_reg_write = 1'b1;
        step("fwd_x0", mk(C_RUN, 2'b00, 2'b00, 0, 0, 2));
        ex_rs1 = 5'd4; wb_rd = 5'd4; ex_rs2 = 5'd3; mem_rd = 5'd3;
        step("fwd_split", mk(C_RUN, 2'b01, 2'b10, 0, 0, 2));
        ex_rs2 = 5'd4;
        step("fwd_both_wb", mk(C_RUN, 2'b01, 2'b01, 0, 0, 2));
        idle_inputs();

        // Multi-cycle op with concurrent load-use and forwarding in EX
        ex_mc_start = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step($sformatf("mc_busy_%0d", i), mk(C_MC, 2'b10, 2'b00, 1, 0, 2 + i));
        end
        ex_mem_read = 1'b0;
        step("mc_done", mk(C_RUN, 2'b10, 2'b00, 0, 1, 10));

        // Back-to-back op, aborted by reset in its fourth cycle
        idle_inputs();
        ex_mc_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("mc2_busy_%0d", i), mk(C_MC, 2'b00, 2'b00, 1, 0, 10 + i));
        end
        reset = 1'b1;
        step("mc2_reset", mk(C_RST, 2'b00, 2'b00, 0, 0, 13));
        reset = 1'b0;
        ex_mc_start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step($sformatf("post_abort_%0d", i), mk(C_RUN, 2'b00, 2'b00, 0, 0, 0));
        end

        // Branch and mc_start together behave as a multi-cycle start
        ex_mc_start = 1'b1; ex_branch_taken = 1'b1;
        step("mc_br_start", mk(C_MC, 2'b00, 2'b00, 1, 0, 0));
        ex_branch_taken = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step($sformatf("mc3_busy_%0d", i), mk(C_MC, 2'b00, 2'b00, 1, 0, i));
        end
        step("mc3_done", mk(C_RUN, 2'b00, 2'b00, 0, 1, 8));
        ex_mc_start = 1'b0;
        step("mc3_after", mk(C_RUN, 2'b00, 2'b00, 0, 0, 8));

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_miscmp++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/forward controller for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register. It also selects EX-stage operand forwarding and sequences multi-cycle EX operations (divider) with an internal FSM and down-counter. A saturating stall-cycle counter is exported for performance monitoring.

## Interface
- MC_LATENCY, 8, total EX cycles of a multi-cycle op; legal range 2..255
- STALL_CNT_W, 32, width of stall-cycle counter
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- ex_rs1, ex_rs2  in  5  source registers of instruction in EX
- ex_rd  in  5  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  EX resolved a taken branch/jump (redirect)
- ex_mc_start  in  1  EX instruction is multi-cycle; held high while it sits in EX
- mem_rd, wb_rd  in  5  destinations in EX/MEM and MEM/WB
- mem_reg_write, wb_reg_write  in  1  write-enables in EX/MEM and MEM/WB
- pc_en, ifid_en, idex_en  out  1  register load enables
- ifid_flush, idex_flush, exmem_flush  out  1  insert bubble (flush wins over enable)
- fwd_a, fwd_b  out  2  operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
- mc_busy  out  1  multi-cycle stall in progress
- mc_done  out  1  one-cycle pulse, multi-cycle result valid this cycle
- stall_cycles  out  STALL_CNT_W  cycles with pc_en=0, saturating

## Operation
- FSM states: RUN, MC_WAIT. Down-counter cnt, 8 bits.
- RUN, ex_mc_start=1: mc_busy=1; next state MC_WAIT, cnt<=MC_LATENCY-1.
- MC_WAIT, cnt!=0: mc_busy=1; cnt<=cnt-1.
- MC_WAIT, cnt==0: mc_busy=0, mc_done=1; next state RUN. ex_mc_start is ignored outside RUN.
- mc_busy=1: pc_en=ifid_en=idex_en=0, exmem_flush=1, ifid_flush=idex_flush=0. Load-use and branch detection are suppressed.
- Load-use, mc_busy=0: ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2) gives pc_en=0, ifid_en=0, idex_flush=1.
- Taken branch, mc_busy=0: ifid_flush=1, idex_flush=1, pc_en=1. Branch overrides load-use, because the dependent instruction is wrong-path.
- Otherwise all enables are 1 and all flushes are 0.
- Priority: reset > mc_busy > branch > load-use > run.
- Forwarding (fwd_a from ex_rs1, fwd_b from ex_rs2):
  - 10 if mem_reg_write & mem_rd!=0 & mem_rd==rs.
  - Else 01 if wb_reg_write & wb_rd!=0 & wb_rd==rs.
  - Else 00.
  - x0 is never forwarded. Forwarding outputs are valid in every state.
- stall_cycles increments in each cycle where pc_en=0. It holds at all-ones.

## Timing
- All control outputs are combinational from state and inputs. State, cnt and stall_cycles are registered.
- Reset cycle outputs: pc_en=ifid_en=idex_en=0, all flushes=1, fwd=00, mc_busy=0, mc_done=0.
- After reset: state=RUN, cnt=0, stall_cycles=0.
- Reset mid-MC_WAIT aborts the op: state=RUN next cycle and no mc_done.
- Multi-cycle op first seen in cycle T: mc_busy is high in cycles T..T+MC_LATENCY-1 (exactly MC_LATENCY stall cycles). mc_done=1 and the pipeline advances in cycle T+MC_LATENCY.
- Back-to-back multi-cycle ops: the next ex_mc_start is seen in RUN at T+MC_LATENCY+1 at the earliest, with no lost cycle.
- Load-use stall lasts one cycle. The next cycle the load is in MEM, and fwd selects 10 or 01 normally.
- ex_branch_taken together with ex_mc_start is illegal (single EX instruction). If both are asserted, the controller treats the cycle as a multi-cycle start.

## Test plan
- Reset held 2 cycles, then released with idle inputs: outputs during reset are as specified; afterwards all enables=1, flushes=0, stall_cycles=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use hazard -> ifid_flush=idex_flush=1, pc_en=1; stall_cycles unchanged.
- Forwarding: mem_rd=wb_rd=7, both write-enables set, ex_rs1=7 -> fwd_a=10. With mem_reg_write=0 -> 01. With rd=0 -> 00.
- Multi-cycle op: MC_LATENCY=8, ex_mc_start held from cycle T -> mc_busy for 8 cycles, exmem_flush=1 throughout, mc_done at T+8, stall_cycles=8. A concurrent load-use pattern is ignored.
- Reset asserted at T+3 of a multi-cycle op -> RUN after reset, mc_done never pulses, stall_cycles=0.
